// File: rtl/apbif_pkg.sv
// Shared register map, FSM encoding and byte-strobe helpers for the multi-channel
// APB register interface of the rotate engine.
package apbif_pkg;

   localparam logic [31:0] CHAN_STRIDE = 32'h20;
   localparam logic [7:0]  VERSION_DEF = 8'h02;

   // Per-channel register word offsets (byte offset / 4)
   localparam logic [2:0] OFF_SRC   = 3'd0;
   localparam logic [2:0] OFF_DST   = 3'd1;
   localparam logic [2:0] OFF_H     = 3'd2;
   localparam logic [2:0] OFF_W     = 3'd3;
   localparam logic [2:0] OFF_NEW_H = 3'd4;
   localparam logic [2:0] OFF_NEW_W = 3'd5;
   localparam logic [2:0] OFF_CFG   = 3'd6;
   localparam logic [2:0] OFF_CTRL  = 3'd7;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess
   } apb_state_e;

   function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i+:8] = strb[i] ? new_v[8*i+:8] : old_v[8*i+:8];
      end
      return res;
   endfunction

   function automatic logic [15:0] apply_strb16(input logic [15:0] old_v,
                                                input logic [15:0] new_v,
                                                input logic [1:0]  strb);
      logic [15:0] res;
      for (int i = 0; i < 2; i++) begin
         res[8*i+:8] = strb[i] ? new_v[8*i+:8] : old_v[8*i+:8];
      end
      return res;
   endfunction

endpackage

// File: rtl/apbif_chregs.sv
// One rotate/DMA channel's register file: byte-strobed writes, read-back mux and
// the self-clearing start pulse.
module apbif_chregs
   import apbif_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        we_i,
   input  logic [2:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  strb_i,
   input  logic [15:0] new_h_i,
   input  logic [15:0] new_w_i,
   output logic [31:0] src_o,
   output logic [31:0] dst_o,
   output logic [15:0] h_o,
   output logic [15:0] w_o,
   output logic [1:0]  mode_o,
   output logic        dir_o,
   output logic        start_o,
   output logic        soft_rst_o,
   output logic [31:0] rdata_o
);

   logic [31:0] src_q, dst_q;
   logic [15:0] h_q, w_q;
   logic [2:0]  cfg_q;
   logic        soft_rst_q, start_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         src_q      <= '0;
         dst_q      <= '0;
         h_q        <= '0;
         w_q        <= '0;
         cfg_q      <= '0;
         soft_rst_q <= 1'b0;
         start_q    <= 1'b0;
      end else begin
         start_q <= we_i && (off_i == OFF_CTRL) && strb_i[0] && wdata_i[0];
         if (we_i) begin
            case (off_i)
               OFF_SRC:  src_q <= apply_strb(src_q, wdata_i, strb_i);
               OFF_DST:  dst_q <= apply_strb(dst_q, wdata_i, strb_i);
               OFF_H:    h_q   <= apply_strb16(h_q, wdata_i[15:0], strb_i[1:0]);
               OFF_W:    w_q   <= apply_strb16(w_q, wdata_i[15:0], strb_i[1:0]);
               OFF_CFG:  if (strb_i[0]) cfg_q <= wdata_i[2:0];
               OFF_CTRL: if (strb_i[0]) soft_rst_q <= wdata_i[1];
               default:  ;
            endcase
         end
      end
   end

   always_comb begin
      rdata_o = '0;
      case (off_i)
         OFF_SRC:   rdata_o = src_q;
         OFF_DST:   rdata_o = dst_q;
         OFF_H:     rdata_o = {16'h0, h_q};
         OFF_W:     rdata_o = {16'h0, w_q};
         OFF_NEW_H: rdata_o = {16'h0, new_h_i};
         OFF_NEW_W: rdata_o = {16'h0, new_w_i};
         OFF_CFG:   rdata_o = {29'h0, cfg_q};
         OFF_CTRL:  rdata_o = {30'h0, soft_rst_q, 1'b0};
         default:   rdata_o = '0;
      endcase
   end

   assign src_o      = src_q;
   assign dst_o      = dst_q;
   assign h_o        = h_q;
   assign w_o        = w_q;
   assign mode_o     = cfg_q[1:0];
   assign dir_o      = cfg_q[2];
   assign start_o    = start_q;
   assign soft_rst_o = soft_rst_q;

endmodule

// File: rtl/apbif_mc.sv
// Multi-channel APB4 slave for the rotate engine: transfer FSM with wait states,
// address decode, read mux, error decode and the masked W1C interrupt block.
module apbif_mc
   import apbif_pkg::*;
#(
   parameter int unsigned NCH         = 2,
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [7:0]  VERSION     = VERSION_DEF
) (
   input  logic                I_APBIF_PCLK,
   input  logic                I_APBIF_PRESET,
   input  logic [ADDR_W-1:0]   I_APBIF_PADDR,
   input  logic                I_APBIF_PSEL,
   input  logic                I_APBIF_PENABLE,
   input  logic                I_APBIF_PWRITE,
   input  logic [31:0]         I_APBIF_PWDATA,
   input  logic [3:0]          I_APBIF_PSTRB,
   output logic [31:0]         O_APBIF_PRDATA,
   output logic                O_APBIF_PREADY,
   output logic                O_APBIF_PSLVERR,
   input  logic [NCH*16-1:0]   I_APBIF_ROT_IMG_NEW_H,
   input  logic [NCH*16-1:0]   I_APBIF_ROT_IMG_NEW_W,
   input  logic [NCH-1:0]      I_APBIF_DONE,
   output logic [NCH*32-1:0]   O_APBIF_DMA_SRC_IMG,
   output logic [NCH*32-1:0]   O_APBIF_DMA_DST_IMG,
   output logic [NCH*16-1:0]   O_APBIF_ROT_IMG_H,
   output logic [NCH*16-1:0]   O_APBIF_ROT_IMG_W,
   output logic [NCH*2-1:0]    O_APBIF_ROT_IMG_MODE,
   output logic [NCH-1:0]      O_APBIF_ROT_IMG_DIR,
   output logic [NCH-1:0]      O_APBIF_CTRL_START,
   output logic [NCH-1:0]      O_APBIF_CTRL_RESET,
   output logic                O_APBIF_IRQ
);

   localparam int unsigned    WA_W     = ADDR_W - 2;
   localparam int unsigned    CH_W     = WA_W - 3;
   localparam logic [WA_W-1:0] G_STAT  = WA_W'(NCH * CHAN_STRIDE / 4);
   localparam logic [WA_W-1:0] G_MASK  = G_STAT + WA_W'(1);
   localparam logic [WA_W-1:0] G_ID    = G_STAT + WA_W'(2);

   apb_state_e      state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic            pready, err, wr_commit;
   logic [WA_W-1:0] waddr;
   logic [CH_W-1:0] ch_idx;
   logic [2:0]      ch_off;
   logic            in_chan, sel_stat, sel_mask, sel_id;
   logic [NCH-1:0]  ch_we, status_q, status_d, mask_q, w1c;
   logic            irq_q;
   logic [31:0]     ch_rdata [NCH];
   logic [31:0]     rdata;
   logic            unused_paddr;

   assign unused_paddr = ^I_APBIF_PADDR[1:0];

   always_ff @(posedge I_APBIF_PCLK) begin
      if (I_APBIF_PRESET) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle:   if (I_APBIF_PSEL && !I_APBIF_PENABLE) state_d = StSetup;
         StSetup: begin
            state_d = StAccess;
            cnt_d   = 3'(WAIT_STATES);
         end
         StAccess: begin
            if (pready) begin
               state_d = (I_APBIF_PSEL && !I_APBIF_PENABLE) ? StSetup : StIdle;
            end else if (!I_APBIF_PSEL) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default:  state_d = StIdle;
      endcase
   end

   assign pready = (state_q == StAccess) && (cnt_q == 3'd0);

   assign waddr    = I_APBIF_PADDR[ADDR_W-1:2];
   assign ch_idx   = waddr[WA_W-1:3];
   assign ch_off   = waddr[2:0];
   assign in_chan  = waddr < G_STAT;
   assign sel_stat = waddr == G_STAT;
   assign sel_mask = waddr == G_MASK;
   assign sel_id   = waddr == G_ID;

   always_comb begin
      err = 1'b1;
      if (in_chan) begin
         err = I_APBIF_PWRITE && ((ch_off == OFF_NEW_H) || (ch_off == OFF_NEW_W));
      end else if (sel_stat || sel_mask) begin
         err = 1'b0;
      end else if (sel_id) begin
         err = I_APBIF_PWRITE;
      end
   end

   assign wr_commit = pready && I_APBIF_PSEL && I_APBIF_PENABLE && I_APBIF_PWRITE && !err;

   always_comb begin
      rdata = '0;
      if (in_chan) begin
         for (int n = 0; n < NCH; n++) begin
            if (ch_idx == CH_W'(n)) rdata = ch_rdata[n];
         end
      end else if (sel_stat) begin
         rdata = 32'(status_q);
      end else if (sel_mask) begin
         rdata = 32'(mask_q);
      end else if (sel_id) begin
         rdata = {16'h0, 8'(NCH), VERSION};
      end
   end

   assign O_APBIF_PREADY  = pready;
   assign O_APBIF_PRDATA  = (pready && !err) ? rdata : '0;
   assign O_APBIF_PSLVERR = pready && err;

   // A DONE arriving in the same cycle as a W1C of that bit wins
   assign w1c      = (wr_commit && sel_stat && I_APBIF_PSTRB[0]) ? I_APBIF_PWDATA[NCH-1:0] : '0;
   assign status_d = (status_q & ~w1c) | I_APBIF_DONE;

   always_ff @(posedge I_APBIF_PCLK) begin
      if (I_APBIF_PRESET) begin
         status_q <= '0;
         mask_q   <= '0;
         irq_q    <= 1'b0;
      end else begin
         status_q <= status_d;
         if (wr_commit && sel_mask && I_APBIF_PSTRB[0]) mask_q <= I_APBIF_PWDATA[NCH-1:0];
         irq_q    <= |(status_q & ~mask_q);
      end
   end

   assign O_APBIF_IRQ = irq_q;

   for (genvar n = 0; n < NCH; n++) begin : g_ch
      assign ch_we[n] = wr_commit && in_chan && (ch_idx == CH_W'(n));

      apbif_chregs u_chregs (
         .clk_i      (I_APBIF_PCLK),
         .rst_i      (I_APBIF_PRESET),
         .we_i       (ch_we[n]),
         .off_i      (ch_off),
         .wdata_i    (I_APBIF_PWDATA),
         .strb_i     (I_APBIF_PSTRB),
         .new_h_i    (I_APBIF_ROT_IMG_NEW_H[16*n+:16]),
         .new_w_i    (I_APBIF_ROT_IMG_NEW_W[16*n+:16]),
         .src_o      (O_APBIF_DMA_SRC_IMG[32*n+:32]),
         .dst_o      (O_APBIF_DMA_DST_IMG[32*n+:32]),
         .h_o        (O_APBIF_ROT_IMG_H[16*n+:16]),
         .w_o        (O_APBIF_ROT_IMG_W[16*n+:16]),
         .mode_o     (O_APBIF_ROT_IMG_MODE[2*n+:2]),
         .dir_o      (O_APBIF_ROT_IMG_DIR[n]),
         .start_o    (O_APBIF_CTRL_START[n]),
         .soft_rst_o (O_APBIF_CTRL_RESET[n]),
         .rdata_o    (ch_rdata[n])
      );
   end

endmodule

// File: tb/tb_apbif_mc.sv
// Scoreboard bench for apbif_mc: a zero-wait-state DUT checked by a PREADY monitor,
// plus a three-wait-state DUT used for latency and mid-transfer reset checks.
module tb_apbif_mc;

   logic        clk = 1'b0;
   logic        preset;
   logic        psel, penable, pwrite, psel3, penable3;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] new_h, new_w;
   logic [1:0]  done;

   logic [31:0] prdata, prdata3;
   logic        pready, pready3, pslverr, pslverr3, irq, irq3;
   logic [63:0] src, dst, src3, dst3;
   logic [31:0] h, w, h3, w3;
   logic [3:0]  mode, mode3;
   logic [1:0]  dir, dir3, start, start3, creset, creset3;

   always #5 clk = ~clk;

   apbif_mc #(.NCH(2), .ADDR_W(12), .WAIT_STATES(0), .VERSION(8'h02)) u_dut (
      .I_APBIF_PCLK(clk), .I_APBIF_PRESET(preset), .I_APBIF_PADDR(paddr),
      .I_APBIF_PSEL(psel), .I_APBIF_PENABLE(penable), .I_APBIF_PWRITE(pwrite),
      .I_APBIF_PWDATA(pwdata), .I_APBIF_PSTRB(pstrb), .O_APBIF_PRDATA(prdata),
      .O_APBIF_PREADY(pready), .O_APBIF_PSLVERR(pslverr),
      .I_APBIF_ROT_IMG_NEW_H(new_h), .I_APBIF_ROT_IMG_NEW_W(new_w), .I_APBIF_DONE(done),
      .O_APBIF_DMA_SRC_IMG(src), .O_APBIF_DMA_DST_IMG(dst), .O_APBIF_ROT_IMG_H(h),
      .O_APBIF_ROT_IMG_W(w), .O_APBIF_ROT_IMG_MODE(mode), .O_APBIF_ROT_IMG_DIR(dir),
      .O_APBIF_CTRL_START(start), .O_APBIF_CTRL_RESET(creset), .O_APBIF_IRQ(irq)
   );

   apbif_mc #(.NCH(2), .ADDR_W(12), .WAIT_STATES(3), .VERSION(8'h02)) u_dut3 (
      .I_APBIF_PCLK(clk), .I_APBIF_PRESET(preset), .I_APBIF_PADDR(paddr),
      .I_APBIF_PSEL(psel3), .I_APBIF_PENABLE(penable3), .I_APBIF_PWRITE(pwrite),
      .I_APBIF_PWDATA(pwdata), .I_APBIF_PSTRB(pstrb), .O_APBIF_PRDATA(prdata3),
      .O_APBIF_PREADY(pready3), .O_APBIF_PSLVERR(pslverr3),
      .I_APBIF_ROT_IMG_NEW_H(new_h), .I_APBIF_ROT_IMG_NEW_W(new_w), .I_APBIF_DONE(2'b00),
      .O_APBIF_DMA_SRC_IMG(src3), .O_APBIF_DMA_DST_IMG(dst3), .O_APBIF_ROT_IMG_H(h3),
      .O_APBIF_ROT_IMG_W(w3), .O_APBIF_ROT_IMG_MODE(mode3), .O_APBIF_ROT_IMG_DIR(dir3),
      .O_APBIF_CTRL_START(start3), .O_APBIF_CTRL_RESET(creset3), .O_APBIF_IRQ(irq3)
   );

   typedef struct {
      logic [11:0] addr;
      logic [31:0] data;
      logic        err;
      logic        chk_data;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   int   last_lat;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Monitor: every completed transfer on the zero-wait DUT is checked against the queue
   always @(negedge clk) begin
      if (pready && psel) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL sb_empty: unexpected PREADY at addr %h", paddr);
         end else begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            if (pslverr !== e.err || (e.chk_data && prdata !== e.data)) begin
               n_miss++;
               $display("FAIL apb@%h: got prdata=%h pslverr=%b, want prdata=%h pslverr=%b",
                        e.addr, prdata, pslverr, e.data, e.err);
            end
         end
      end
   end

   task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] exp_d, input logic exp_e,
                      input logic chk_d);
      exp_t e;
      int   k;
      e.addr = a; e.data = exp_d; e.err = exp_e; e.chk_data = chk_d;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
      sb.push_back(e);
      @(posedge clk); #1 penable = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!pready && k < 20);
      last_lat = k;
      if (!pready) begin
         n_vec++;
         n_miss++;
         $display("FAIL timeout@%h: got no PREADY, want PREADY within 20 cycles", a);
         e = sb.pop_back();
      end
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
   endtask

   task automatic apb3(input logic wr, input logic [11:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat);
      int k;
      @(posedge clk); #1;
      psel3 = 1'b1; penable3 = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = 4'hF;
      @(posedge clk); #1 penable3 = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!pready3 && k < 20);
      lat = k;
      rd  = prdata3;
      er  = pslverr3;
      @(posedge clk); #1 psel3 = 1'b0; penable3 = 1'b0;
   endtask

   task automatic pulse_done1();
      @(posedge clk); #1 done = 2'b10;
      @(posedge clk); #1 done = 2'b00;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic        seen;

      preset = 1'b1; psel = 1'b0; penable = 1'b0; psel3 = 1'b0; penable3 = 1'b0;
      pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0; done = '0;
      new_h = {16'h0456, 16'h0123};
      new_w = {16'h0789, 16'h0ABC};
      repeat (3) @(posedge clk);
      #1 preset = 1'b0;
      @(negedge clk);
      check("rst_ctl", {prdata, pready, pslverr, irq, start, creset}, '0);
      check("rst_src", src, '0);
      check("rst_dst", dst, '0);
      check("rst_hwmd", {h, w, mode, dir}, '0);

      // Full-word write and read-back
      apb(1'b1, 12'h020, 32'hDEADBEEF, 4'hF, '0, 1'b0, 1'b0);
      check("src1_out", src[63:32], 64'hDEADBEEF);
      check("src0_out", src[31:0], 64'h0);
      apb(1'b0, 12'h020, '0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1);
      check("lat_w0", last_lat, 64'd2);

      // Byte strobes
      apb(1'b1, 12'h004, 32'h11223344, 4'hF, '0, 1'b0, 1'b0);
      apb(1'b1, 12'h004, 32'h0000AB00, 4'b0010, '0, 1'b0, 1'b0);
      apb(0, 12'h004, '0, 4'hF, 32'h1122AB44, 1'b0, 1'b1);
      check("dst0_out", dst[31:0], 64'h1122AB44);
      apb(1'b1, 12'h028, 32'hFFFFBEEF, 4'b0010, '0, 1'b0, 1'b0);
      apb(1'b0, 12'h028, '0, 4'hF, 32'h0000BE00, 1'b0, 1'b1);
      apb(1'b1, 12'h038, 32'hFFFFFFFF, 4'hF, '0, 1'b0, 1'b0);
      check("cfg1_out", {mode[3:2], dir[1]}, 64'h7);
      apb(1'b0, 12'h038, '0, 4'hF, 32'h00000007, 1'b0, 1'b1);

      // Start pulse and soft reset
      apb(1'b1, 12'h01C, 32'h1, 4'hF, '0, 1'b0, 1'b0);
      check("start_pulse", start, 64'h1);
      @(posedge clk); #1;
      check("start_clear", start, 64'h0);
      apb(1'b0, 12'h01C, '0, 4'hF, 32'h0, 1'b0, 1'b1);
      apb(1'b1, 12'h01C, 32'h2, 4'hF, '0, 1'b0, 1'b0);
      check("ctrl_reset", {start, creset}, 64'h1);
      apb(1'b0, 12'h01C, '0, 4'hF, 32'h2, 1'b0, 1'b1);

      // Error responses
      apb(1'b1, 12'h010, 32'h5555, 4'hF, '0, 1'b1, 1'b0);
      apb(1'b0, 12'h010, '0, 4'hF, 32'h00000123, 1'b0, 1'b1);
      apb(1'b0, 12'h034, '0, 4'hF, 32'h00000789, 1'b0, 1'b1);
      apb(1'b1, 12'h04C, 32'hFFFFFFFF, 4'hF, '0, 1'b1, 1'b0);
      apb(1'b0, 12'h04C, '0, 4'hF, 32'h0, 1'b1, 1'b1);
      apb(1'b1, 12'h048, 32'hFFFFFFFF, 4'hF, '0, 1'b1, 1'b0);
      apb(1'b0, 12'h048, '0, 4'hF, 32'h00000202, 1'b0, 1'b1);
      apb(1'b0, 12'h040, '0, 4'hF, 32'h0, 1'b0, 1'b1);
      apb(1'b0, 12'h000, '0, 4'hF, 32'h0, 1'b0, 1'b1);

      // Interrupt latency
      @(posedge clk); #1 done = 2'b10;
      check("irq_t0", irq, 64'h0);
      @(posedge clk); #1 done = 2'b00;
      check("irq_t1", irq, 64'h0);
      @(posedge clk); #1;
      check("irq_t2", irq, 64'h1);
      apb(1'b0, 12'h040, '0, 4'hF, 32'h2, 1'b0, 1'b1);

      // W1C colliding with a fresh DONE: set wins
      fork
         apb(1'b1, 12'h040, 32'h2, 4'hF, '0, 1'b0, 1'b0);
         begin : b_done_hit
            int k;
            k = 0;
            do begin
               @(negedge clk);
               k++;
            end while (!pready && k < 20);
            done = 2'b10;
            @(posedge clk); #1 done = 2'b00;
         end
      join
      apb(1'b0, 12'h040, '0, 4'hF, 32'h2, 1'b0, 1'b1);
      check("irq_held", irq, 64'h1);

      // Plain W1C
      apb(1'b1, 12'h040, 32'h2, 4'hF, '0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("irq_clear", irq, 64'h0);
      apb(1'b0, 12'h040, '0, 4'hF, 32'h0, 1'b0, 1'b1);

      // Masked source sets status but not IRQ
      apb(1'b1, 12'h044, 32'h2, 4'hF, '0, 1'b0, 1'b0);
      pulse_done1();
      repeat (3) @(posedge clk);
      #1 check("irq_masked", irq, 64'h0);
      apb(1'b0, 12'h040, '0, 4'hF, 32'h2, 1'b0, 1'b1);
      apb(1'b0, 12'h044, '0, 4'hF, 32'h2, 1'b0, 1'b1);

      // Wait-state DUT latency
      apb3(1'b1, 12'h000, 32'h12345678, rd, er, lat);
      check("lat_w3_wr", lat, 64'd5);
      check("src3_out", src3[31:0], 64'h12345678);
      apb3(1'b0, 12'h000, '0, rd, er, lat);
      check("lat_w3_rd", lat, 64'd5);
      check("rd3_data", {er, rd}, 64'h12345678);

      // Reset during an ACCESS wait state of a write
      @(posedge clk); #1;
      psel3 = 1'b1; penable3 = 1'b0; pwrite = 1'b1; paddr = 12'h004;
      pwdata = 32'hCAFEF00D; pstrb = 4'hF;
      @(posedge clk); #1 penable3 = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid_not_ready", pready3, 64'h0);
      preset = 1'b1;
      @(posedge clk); #1 preset = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (pready3) seen = 1'b1;
      end
      check("mid_no_ready", seen, 64'h0);
      @(posedge clk); #1 psel3 = 1'b0; penable3 = 1'b0;
      check("mid_src3", src3, 64'h0);
      check("mid_dst3", dst3, 64'h0);
      check("mid_ctl3", {h3, w3, mode3, dir3, start3, creset3, irq3}, '0);
      check("mid_dut0", {dst[31:0], creset, irq}, '0);
      apb3(1'b1, 12'h004, 32'h0BADF00D, rd, er, lat);
      check("post_lat_wr", {er, 32'(lat)}, 64'd5);
      apb3(1'b0, 12'h004, '0, rd, er, lat);
      check("post_rd3", {er, rd}, 64'h0BADF00D);
      check("post_dst3", dst3[31:0], 64'h0BADF00D);
      apb(1'b0, 12'h020, '0, 4'hF, 32'h0, 1'b0, 1'b1);
      apb(1'b0, 12'h044, '0, 4'hF, 32'h0, 1'b0, 1'b1);

      repeat (2) @(posedge clk);
      check("sb_drained", sb.size(), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
